// File: rtl/neuron_weight_fetcher.sv
// Streams NUM_WEIGHTS words from a registered-output ROM to a valid/ready sink; first weight 2 cycles after start.
// Credits cover the FIFO plus both ROM pipeline stages, so backpressure stalls address issue instead of dropping words.
module neuron_weight_fetcher #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int BASE_ADDR   = 1,
    parameter int NUM_WEIGHTS = 10,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_dout,
    output logic [DATA_W-1:0] w_data,
    output logic              w_valid,
    input  logic              w_ready,
    output logic              w_last,
    output logic [ADDR_W-1:0] w_index
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_WEIGHTS - 1);
    localparam logic [CNT_W:0]    DEPTH_C  = (CNT_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] issue_idx_q, issue_idx_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              s1_vld_q, s2_vld_q;
    logic [ADDR_W-1:0] s1_idx_q, s2_idx_q;

    logic [DATA_W-1:0] fifo_dat_q  [FIFO_DEPTH];
    logic [ADDR_W-1:0] fifo_idx_q  [FIFO_DEPTH];
    logic              fifo_last_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              issue;
    logic [ADDR_W-1:0] cur_idx;
    logic [CNT_W:0]    occ;
    logic              credit_ok;
    logic              fifo_empty;
    logic              pop, push_store, pop_store;
    logic [DATA_W-1:0] head_dat;
    logic [ADDR_W-1:0] head_idx;
    logic              head_last;

    // s1: address on the ROM bus; s2: rom_dout carries that word this cycle.
    assign occ = {1'b0, cnt_q} + {{CNT_W{1'b0}}, s1_vld_q} + {{CNT_W{1'b0}}, s2_vld_q};
    assign credit_ok  = occ < DEPTH_C;
    assign cur_idx    = (state_q == S_IDLE) ? '0 : issue_idx_q;
    assign fifo_empty = (cnt_q == '0);

    // An empty FIFO lets the arriving ROM word through directly; it is stored if not taken.
    assign head_dat  = fifo_empty ? rom_dout : fifo_dat_q[rd_ptr_q];
    assign head_idx  = fifo_empty ? s2_idx_q : fifo_idx_q[rd_ptr_q];
    assign head_last = fifo_empty ? (s2_idx_q == LAST_IDX) : fifo_last_q[rd_ptr_q];

    assign w_valid = !fifo_empty || s2_vld_q;
    assign w_data  = w_valid ? head_dat : '0;
    assign w_index = w_valid ? head_idx : '0;
    assign w_last  = w_valid && head_last;

    assign pop        = w_valid && w_ready;
    assign push_store = s2_vld_q && !(fifo_empty && pop);
    assign pop_store  = pop && !fifo_empty;

    assign busy     = (state_q == S_FETCH) || (state_q == S_DRAIN);
    assign done     = (state_q == S_DONE);
    assign rom_addr = rom_addr_q;

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    issue   = 1'b1;
                    state_d = (LAST_IDX == '0) ? S_DRAIN : S_FETCH;
                end
            end
            S_FETCH: begin
                if (credit_ok) begin
                    issue = 1'b1;
                    if (issue_idx_q == LAST_IDX) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (pop && head_last) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        issue_idx_d = issue ? cur_idx + ADDR_W'(1) : issue_idx_q;
        rom_addr_d  = issue ? BASE + cur_idx : rom_addr_q;
        cnt_d       = cnt_q;
        if (push_store && !pop_store)      cnt_d = cnt_q + CNT_W'(1);
        else if (!push_store && pop_store) cnt_d = cnt_q - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            issue_idx_q <= '0;
            rom_addr_q  <= '0;
            s1_vld_q    <= 1'b0;
            s2_vld_q    <= 1'b0;
            s1_idx_q    <= '0;
            s2_idx_q    <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            issue_idx_q <= issue_idx_d;
            rom_addr_q  <= rom_addr_d;
            s1_vld_q    <= issue;
            s1_idx_q    <= cur_idx;
            s2_vld_q    <= s1_vld_q;
            s2_idx_q    <= s1_idx_q;
            cnt_q       <= cnt_d;
            if (push_store) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_store)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_store) begin
            fifo_dat_q[wr_ptr_q]  <= rom_dout;
            fifo_idx_q[wr_ptr_q]  <= s2_idx_q;
            fifo_last_q[wr_ptr_q] <= (s2_idx_q == LAST_IDX);
        end
    end

endmodule

// File: tb/tb_neuron_weight_fetcher.sv
// Directed bench: scoreboard of expected weights, checked on every handshake plus hold-while-stalled checks.
module tb_neuron_weight_fetcher;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, w_ready;
    logic        busy, done, w_valid, w_last;
    logic [15:0] rom_addr, rom_dout, w_data, w_index;

    logic        start2, w_ready2;
    logic        busy2, done2, w_valid2, w_last2;
    logic [15:0] rom_addr2, rom_dout2, w_data2, w_index2;

    int checks   = 0;
    int failures = 0;
    int xfers    = 0;
    int base_x;
    int cyc;
    logic [32:0] expq[$];

    neuron_weight_fetcher dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .rom_addr(rom_addr), .rom_dout(rom_dout), .w_data(w_data), .w_valid(w_valid),
        .w_ready(w_ready), .w_last(w_last), .w_index(w_index)
    );

    neuron_weight_fetcher #(.NUM_WEIGHTS(1), .BASE_ADDR(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2),
        .rom_addr(rom_addr2), .rom_dout(rom_dout2), .w_data(w_data2), .w_valid(w_valid2),
        .w_ready(w_ready2), .w_last(w_last2), .w_index(w_index2)
    );

    function automatic logic [15:0] rom_val(input logic [15:0] a);
        case (a)
            16'd1:   return 16'd1;
            16'd2:   return 16'd3;
            16'd3:   return 16'd4;
            16'd4:   return 16'd5;
            16'd5:   return 16'd6;
            16'd6:   return 16'd8;
            default: return 16'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        rom_dout  <= rom_val(rom_addr);
        rom_dout2 <= rom_val(rom_addr2);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_seq();
        for (int i = 0; i < 10; i++)
            expq.push_back({rom_val(16'(i + 1)), 16'(i), 1'(i == 9)});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string tag, input int budget, output int cycles);
        cycles = 0;
        while (!done && cycles < budget) begin
            @(negedge clk);
            cycles++;
        end
        chk(tag, done, 1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Scoreboard and hold monitor for the main instance.
    logic        stall_q = 1'b0;
    logic [32:0] held_q  = '0;
    always @(negedge clk) begin
        if (rst) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q) chk("hold", {w_valid, w_data, w_index, w_last}, {1'b1, held_q});
            if (w_valid && w_ready) begin
                xfers++;
                chk("xfer_expected", expq.size() != 0, 1);
                if (expq.size() != 0) chk("xfer_word", {w_data, w_index, w_last}, expq.pop_front());
            end
            stall_q = w_valid && !w_ready;
            held_q  = {w_data, w_index, w_last};
        end
    end

    initial begin
        rst = 1'b1; start = 1'b0; w_ready = 1'b1; start2 = 1'b0; w_ready2 = 1'b1;
        repeat (2) step();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_w_valid", w_valid, 0);
        chk("rst_w_last", w_last, 0);
        chk("rst_w_data", w_data, 0);
        chk("rst_w_index", w_index, 0);
        rst = 1'b0;
        step();

        // 1) free-flowing fetch with exact latencies
        base_x = xfers;
        push_seq();
        pulse_start();
        chk("t1_busy", busy, 1);
        for (int k = 1; k <= 10; k++) begin
            chk("t1_rom_addr", rom_addr, 64'(k));
            if (k == 1) chk("t1_valid_t1", w_valid, 0);
            if (k == 2) chk("t1_valid_t2", w_valid, 1);
            step();
        end
        wait_done("t1_done", 20, cyc);
        chk("t1_done_latency", cyc, 2);
        chk("t1_busy_at_done", busy, 0);
        step();
        chk("t1_done_pulse", done, 0);
        chk("t1_queue_empty", expq.size(), 0);
        chk("t1_xfers", xfers - base_x, 10);

        // 2) full backpressure then release
        base_x = xfers;
        w_ready = 1'b0;
        push_seq();
        pulse_start();
        repeat (7) step();
        chk("t2_addr_stall", rom_addr, 4);
        chk("t2_head_valid", w_valid, 1);
        chk("t2_head_index", w_index, 0);
        chk("t2_no_xfer", xfers - base_x, 0);
        step();
        chk("t2_addr_still", rom_addr, 4);
        w_ready = 1'b1;
        wait_done("t2_done", 100, cyc);
        step();
        chk("t2_queue_empty", expq.size(), 0);
        chk("t2_xfers", xfers - base_x, 10);

        // 3) alternating ready
        base_x = xfers;
        push_seq();
        pulse_start();
        for (int c = 0; c < 200 && !done; c++) begin
            w_ready = ~w_ready;
            step();
        end
        chk("t3_done", done, 1);
        w_ready = 1'b1;
        step();
        chk("t3_queue_empty", expq.size(), 0);
        chk("t3_xfers", xfers - base_x, 10);

        // 4) start while busy is ignored; restart after done is fresh
        base_x = xfers;
        push_seq();
        pulse_start();
        repeat (3) step();
        pulse_start();
        wait_done("t4_done", 100, cyc);
        repeat (4) step();
        chk("t4_no_second_seq", w_valid, 0);
        chk("t4_idle", busy, 0);
        chk("t4_xfers", xfers - base_x, 10);
        base_x = xfers;
        push_seq();
        pulse_start();
        wait_done("t4_done_b", 100, cyc);
        step();
        chk("t4b_queue_empty", expq.size(), 0);
        chk("t4b_xfers", xfers - base_x, 10);

        // 5) reset while index 4 is being transferred
        push_seq();
        pulse_start();
        cyc = 0;
        while (!(w_valid && w_index == 16'd4) && cyc < 50) begin
            step();
            cyc++;
        end
        chk("t5_found_idx4", w_valid && w_index == 16'd4, 1);
        rst = 1'b1;
        step();
        chk("t5_busy", busy, 0);
        chk("t5_done", done, 0);
        chk("t5_rom_addr", rom_addr, 0);
        chk("t5_w_valid", w_valid, 0);
        chk("t5_w_data", w_data, 0);
        chk("t5_w_index", w_index, 0);
        chk("t5_w_last", w_last, 0);
        rst = 1'b0;
        expq.delete();
        repeat (3) step();
        chk("t5_no_stale", w_valid, 0);
        base_x = xfers;
        push_seq();
        pulse_start();
        wait_done("t5_done_new", 100, cyc);
        step();
        chk("t5_queue_empty", expq.size(), 0);
        chk("t5_xfers", xfers - base_x, 10);

        // 6) single-word fetch from address 2
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        chk("t6_rom_addr", rom_addr2, 2);
        chk("t6_valid_early", w_valid2, 0);
        chk("t6_busy", busy2, 1);
        step();
        chk("t6_valid", w_valid2, 1);
        chk("t6_data", w_data2, 3);
        chk("t6_last", w_last2, 1);
        chk("t6_index", w_index2, 0);
        chk("t6_done_early", done2, 0);
        step();
        chk("t6_done", done2, 1);
        chk("t6_valid_after", w_valid2, 0);
        chk("t6_busy_after", busy2, 0);
        step();
        chk("t6_done_pulse", done2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
